// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: format codes (also used as the decoder's
// imm_sel), the canonical NOP word, encoder states and an immediate-fit helper.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'b000,
        FMT_I = 3'b001,
        FMT_S = 3'b010,
        FMT_B = 3'b011,
        FMT_U = 3'b100,
        FMT_J = 3'b101
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } enc_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when v is representable as an nbits-wide two's complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] s;
        s = $unsigned($signed(v) >>> (nbits - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: instruction fields + format code -> 32-bit word.
// Immediate range flagging is only built with IMM_RANGE_CHECK_EN defined.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        imm_bad
);

    always_comb begin
        word = NOP_INSTR;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = NOP_INSTR;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // B/J offsets must also be halfword aligned since bit 0 is not encoded.
    always_comb begin
        imm_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: imm_bad = !fits_signed(imm, 12);
            FMT_B:        imm_bad = !fits_signed(imm, 13) || imm[0];
            FMT_U:        imm_bad = |imm[11:0];
            FMT_J:        imm_bad = !fits_signed(imm, 21) || imm[0];
            default:      imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words into an instruction memory, one word per
// accepted bundle. Optional immediate range flagging via IMM_RANGE_CHECK_EN.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              last,
    input  logic              clear,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err,
    output enc_state_e        dbg_state
);

    // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and the bundle may change after transfer.

    localparam int unsigned     CAP_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CAP   = CAP_I[ADDR_W:0];

    enc_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic            last_q, last_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            err_q, err_d;

    logic [31:0]     word;
    logic            imm_bad;
    logic [ADDR_W:0] slots;
    logic            accept;

    instr_pack u_pack (
        .fmt     (fmt),
        .opcode  (opcode),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct3  (funct3),
        .funct7  (funct7),
        .imm     (imm),
        .word    (word),
        .imm_bad (imm_bad)
    );

    // Slots counts the in-flight write so the last free word is never double-booked.
    assign slots    = count_q + {{ADDR_W{1'b0}}, we_q};
    assign full     = (count_q == CAP);
    assign in_ready = !full && (slots < CAP) && (state_q != ST_DONE)
                      && !(we_q && last_q) && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        we_d    = accept;
        last_d  = accept && last;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q + {{ADDR_W{1'b0}}, we_q};
        err_d   = err_q | (accept & imm_bad);

        if (accept) begin
            wdata_d = word;
            addr_d  = BASE_ADDR + (32'(slots) << 2);
        end

        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_WRITE;
            ST_WRITE: begin
                if (last_q)      state_d = ST_DONE;
                else if (accept) state_d = ST_WRITE;
                else             state_d = ST_IDLE;
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
            last_d  = 1'b0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder (ADDR_W=2): directed cases plus random bundles checked
// against an arithmetic encoding model and an expected-write queue.
module tb_instr_encoder;
    import riscv_pkg::*;

    localparam int          ADDR_W = 2;
    localparam int          CAP    = 4;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst, in_valid, last, clear;
    logic [2:0]      fmt, funct3;
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [31:0]     imm;
    logic            in_ready, imem_we, full, done, err;
    logic [31:0]     imem_addr, imem_wdata;
    logic [ADDR_W:0] count;
    enc_state_e      dbg_state;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .last(last), .clear(clear),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from shifted/masked fields.
    function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] base;
        base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        case (f)
            3'd0: return base | (32'(f7) << 25) | (32'(s2) << 20) | (32'(d) << 7);
            3'd1: return base | ((im & 32'hFFF) << 20) | (32'(d) << 7);
            3'd2: return base | (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20)
                              | ((im & 32'h1F) << 7);
            3'd3: return base | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                              | (32'(s2) << 20) | (((im >> 1) & 32'hF) << 8)
                              | (((im >> 11) & 32'h1) << 7);
            3'd4: return (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
            3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                       | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                       | (32'(d) << 7) | 32'(op);
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic bit ref_bad(input logic [2:0] f, input logic [31:0] im);
`ifdef IMM_RANGE_CHECK_EN
        int s;
        s = $signed(im);
        case (f)
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3:       return (s < -4096) || (s > 4095) || (s % 2 != 0);
            3'd4:       return (im % 4096) != 0;
            3'd5:       return (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            default:    return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          lst;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   ncyc = 0;
    bit   mon_en = 0;
    int   m_count = 0;
    bit   m_done = 0, m_err = 0;
    bit   wr_now, wr_last, exp_rdy;

    // Observe at the falling edge; model values describe the current register state.
    always @(negedge clk) begin
        ncyc++;
        if (mon_en) begin
            wr_now  = 0;
            wr_last = 0;
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_write", 32'(imem_we), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("write_addr", imem_addr, e.addr);
                    chk("write_data", imem_wdata, e.data);
                    wr_now  = 1;
                    wr_last = e.lst;
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= ncyc) begin
                chk("write_strobe", 32'(imem_we), 32'd1);
                void'(exp_q.pop_front());
            end
            chk("count", 32'(count), 32'(m_count));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("full", 32'(full), 32'(m_count == CAP));
            exp_rdy = !m_done && !clear && !(wr_now && wr_last) && (m_count + int'(wr_now) < CAP);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));

            if (rst || clear) begin
                m_count = 0;
                m_done  = 0;
                m_err   = 0;
                exp_q.delete();
            end else begin
                m_count += int'(wr_now);
                if (wr_now && wr_last) m_done = 1;
                if (in_valid && exp_rdy) begin
                    e.addr = BASE + 32'(m_count * 4);
                    e.data = ref_word(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                    e.lst  = last;
                    e.due  = ncyc + 1;
                    exp_q.push_back(e);
                    if (ref_bad(fmt, imm)) m_err = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Presents a bundle and returns just after the edge that accepts it.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im, input logic lst);
        bit got;
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im; last = lst;
        in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1;
        end
        if (!got) chk("accept_timeout", 32'(in_ready), 32'd1);
        step();
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 4200)) - 32'd2100;
            1:       return (32'($urandom_range(0, 8000)) - 32'd4000) & ~32'h1;
            2:       return $urandom() & 32'hFFFF_F000;
            default: return $urandom();
        endcase
    endfunction

    task automatic send_rand(input logic lst);
        send(3'($urandom_range(0, 7)), 7'($urandom()), 5'($urandom()), 5'($urandom()),
             5'($urandom()), 3'($urandom()), 7'($urandom()), rand_imm(), lst);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; clear = 1'b0;
        idle();
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;
        step();
        step();
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        step();

        // I-type addi x1, x0, 5
        send(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0);
        idle();
        @(negedge clk);
        chk("i_we", 32'(imem_we), 32'd1);
        chk("i_word", imem_wdata, 32'h0050_0093);
        chk("i_addr", imem_addr, BASE);
        step();

        send(3'b010, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0);
        idle();
        @(negedge clk);
        chk("s_word", imem_wdata, 32'h0020_A423);
        step();

        send(3'b011, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd4, 1'b0);
        idle();
        @(negedge clk);
        chk("b_word", imem_wdata, 32'hFE00_0EE3);
        step();
        pulse_clear();

        // Three back-to-back bundles, final one tagged last
        send_rand(1'b0);
        send_rand(1'b0);
        send_rand(1'b1);
        idle();
        @(negedge clk);
        chk("stream_third_addr", imem_addr, BASE + 32'd8);
        step();
        @(negedge clk);
        chk("stream_done", 32'(done), 32'd1);
        chk("stream_ready_low", 32'(in_ready), 32'd0);
        step();
        pulse_clear();
        @(negedge clk);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_state", 32'(dbg_state), 32'(ST_IDLE));
        step();

        // Fill all four words, then hold a fifth bundle against the full memory
        for (int k = 0; k < 4; k++) send_rand(1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_stall_ready", 32'(in_ready), 32'd0);
            step();
        end
        @(negedge clk);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'(CAP));
        step();
        idle();
        pulse_clear();

        // Reset while the next bundle is being offered: nothing more is written
        send_rand(1'b0);
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_mid_we", 32'(imem_we), 32'd0);
        chk("rst_mid_addr", imem_addr, BASE);
        chk("rst_mid_wdata", imem_wdata, 32'd0);
        chk("rst_mid_count", 32'(count), 32'd0);
        step();
        idle();
        rst = 1'b0;
        step();

        // Out-of-range I immediate: written truncated, err only with range checking
        send(3'b001, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1'b0);
        idle();
        @(negedge clk);
        chk("imm2048_word", imem_wdata, 32'h8000_0013);
        step();
        @(negedge clk);
`ifdef IMM_RANGE_CHECK_EN
        chk("imm2048_err", 32'(err), 32'd1);
`else
        chk("imm2048_err", 32'(err), 32'd0);
`endif
        step();
        pulse_clear();

        // Random batches of up to three bundles with occasional gaps
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                send_rand((k == n - 1) && ($urandom_range(0, 1) == 1));
                if ($urandom_range(0, 2) == 0) begin
                    idle();
                    step();
                end
            end
            idle();
            repeat (3) step();
            pulse_clear();
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
